// File: rtl/jacobi_pivot_scan_pkg.sv
// Shared types and helpers for the Jacobi pivot scanner: state encoding,
// the default element width, saturating |x| and the upper-triangle pair count.
package jacobi_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // The most-negative value has no positive twin, so it clips to the largest positive value.
  function automatic logic [DATA_W_DEF-1:0] abs_sat_fn(input logic [DATA_W_DEF-1:0] x);
    logic [DATA_W_DEF-1:0] min_neg;
    min_neg = {1'b1, {(DATA_W_DEF-1){1'b0}}};
    if (x == min_neg)
      return ~min_neg;
    else if (x[DATA_W_DEF-1])
      return '0 - x;
    else
      return x;
  endfunction

  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

endpackage

// File: rtl/jacobi_pivot_scan_abs_sat.sv
// Combinational saturating absolute value of a signed DATA_W-bit element.
module abs_sat
  import jacobi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  generate
    if (DATA_W == DATA_W_DEF) begin : g_pkg_width
      assign y = abs_sat_fn(x);
    end else begin : g_any_width
      localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
      always_comb begin
        y = x;
        if (x == MIN_NEG)
          y = ~MIN_NEG;
        else if (x[DATA_W-1])
          y = '0 - x;
      end
    end
  endgenerate

endmodule

// File: rtl/jacobi_pivot_scan.sv
// NxN signed matrix store with a sequential largest-|M_ij| upper-triangle pivot scan.
// Optional build macro PIVOT_THRESH_EN adds thresh input and converged output.
module jacobi_pivot_scan
  import jacobi_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_row,
  input  logic [IDX_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_row,
  input  logic [IDX_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  input  logic              start,
`ifdef PIVOT_THRESH_EN
  input  logic [DATA_W-1:0] thresh,
  output logic              converged,
`endif
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  pivot_i,
  output logic [IDX_W-1:0]  pivot_j,
  output logic [DATA_W-1:0] M_ij,
  output logic [DATA_W-1:0] M_abs
);

  generate
    if (N < 2) begin : g_bad_n
      $error("jacobi_pivot_scan: N must be at least 2");
    end
  endgenerate

  localparam int NP = num_pairs(N);
  localparam int CW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [DATA_W-1:0] mem [N][N];
  logic [1:0]        state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [IDX_W-1:0]  i_reg, j_reg, best_i_reg, best_j_reg;
  logic [DATA_W-1:0] best_val_reg, best_abs_reg;
  logic [DATA_W-1:0] rd_data_reg, m_ij_reg, m_abs_reg;
  logic [IDX_W-1:0]  pivot_i_reg, pivot_j_reg;

  logic [DATA_W-1:0] cand_val, cand_abs;
  logic [IDX_W-1:0]  best_i_next, best_j_next;
  logic [DATA_W-1:0] best_val_next, best_abs_next;
  logic              take, last, wr_ok, rd_ok, start_ok;

  assign wr_ok    = wr_en && (state_reg == ST_IDLE) && !start &&
                    ({1'b0, wr_row} < N_LIM) && ({1'b0, wr_col} < N_LIM);
  assign rd_ok    = ({1'b0, rd_row} < N_LIM) && ({1'b0, rd_col} < N_LIM);
  assign start_ok = start && (state_reg == ST_IDLE);

  assign cand_val = mem[i_reg][j_reg];

  abs_sat #(.DATA_W(DATA_W)) u_abs_sat (
    .x (cand_val),
    .y (cand_abs)
  );

  // Strict compare keeps the earliest element on ties; the first pair always seeds best.
  assign take          = (cnt_reg == '0) || (cand_abs > best_abs_reg);
  assign last          = (cnt_reg == CW'(NP - 1));
  assign best_i_next   = take ? i_reg    : best_i_reg;
  assign best_j_next   = take ? j_reg    : best_j_reg;
  assign best_val_next = take ? cand_val : best_val_reg;
  assign best_abs_next = take ? cand_abs : best_abs_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mem[r][c] <= '0;
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      i_reg        <= '0;
      j_reg        <= '0;
      best_i_reg   <= '0;
      best_j_reg   <= '0;
      best_val_reg <= '0;
      best_abs_reg <= '0;
      rd_data_reg  <= '0;
      m_ij_reg     <= '0;
      m_abs_reg    <= '0;
      pivot_i_reg  <= '0;
      pivot_j_reg  <= '0;
    end else begin
      rd_data_reg <= rd_ok ? mem[rd_row][rd_col] : '0;
      if (wr_ok)
        mem[wr_row][wr_col] <= wr_data;

      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            state_reg    <= ST_SCAN;
            cnt_reg      <= '0;
            i_reg        <= '0;
            j_reg        <= IDX_W'(1);
            best_i_reg   <= '0;
            best_j_reg   <= IDX_W'(1);
            best_val_reg <= '0;
            best_abs_reg <= '0;
          end
        end
        ST_SCAN: begin
          best_i_reg   <= best_i_next;
          best_j_reg   <= best_j_next;
          best_val_reg <= best_val_next;
          best_abs_reg <= best_abs_next;
          cnt_reg      <= cnt_reg + CW'(1);
          // Row-major walk of the strict upper triangle.
          if (j_reg == IDX_W'(N - 1)) begin
            i_reg <= i_reg + IDX_W'(1);
            j_reg <= IDX_W'(i_reg + 2);
          end else begin
            j_reg <= j_reg + IDX_W'(1);
          end
          if (last) begin
            state_reg   <= ST_DONE;
            pivot_i_reg <= best_i_next;
            pivot_j_reg <= best_j_next;
            m_ij_reg    <= best_val_next;
            m_abs_reg   <= best_abs_next;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef PIVOT_THRESH_EN
  logic converged_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      converged_reg <= 1'b0;
    else if (start_ok)
      converged_reg <= 1'b0;
    else if ((state_reg == ST_SCAN) && last)
      converged_reg <= (best_abs_next < thresh);
  end

  assign converged = converged_reg;
`endif

  assign rd_data = rd_data_reg;
  assign busy    = (state_reg == ST_SCAN);
  assign done    = (state_reg == ST_DONE);
  assign pivot_i = pivot_i_reg;
  assign pivot_j = pivot_j_reg;
  assign M_ij    = m_ij_reg;
  assign M_abs   = m_abs_reg;

endmodule

// File: tb/tb_jacobi_pivot_scan.sv
// Scoreboard bench for jacobi_pivot_scan (N=4): queued expectations, checked by a negedge monitor.
module tb_jacobi_pivot_scan;

  localparam int N  = 4;
  localparam int NP = N * (N - 1) / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        start = 1'b0;
  logic        busy, done;
  logic [1:0]  pivot_i, pivot_j;
  logic [31:0] M_ij, M_abs;
  logic [31:0] thresh = 32'd10;
`ifdef PIVOT_THRESH_EN
  logic        converged;
`endif

  jacobi_pivot_scan #(.N(N), .DATA_W(32)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data),
    .start   (start),
`ifdef PIVOT_THRESH_EN
    .thresh    (thresh),
    .converged (converged),
`endif
    .busy    (busy),
    .done    (done),
    .pivot_i (pivot_i),
    .pivot_j (pivot_j),
    .M_ij    (M_ij),
    .M_abs   (M_abs)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [1:0]  pi, pj;
    logic [31:0] mij, mabs;
    logic        conv;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] v;
  } rd_t;

  exp_t        exp_q[$];
  rd_t         rd_q[$];
  logic [31:0] model [N][N];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain exhaustive search over i<j with a saturated magnitude.
  function automatic exp_t model_pivot(input int due);
    exp_t   e;
    longint best, a;
    best = -1;
    e.cyc = due; e.pi = '0; e.pj = '0; e.mij = '0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++) begin
        a = longint'($signed(model[i][j]));
        if (a < 0) a = -a;
        if (a > 2147483647) a = 2147483647;
        if (a > best) begin
          best  = a;
          e.pi  = 2'(i);
          e.pj  = 2'(j);
          e.mij = model[i][j];
        end
      end
    e.mabs = 32'(best);
    e.conv = (best < longint'({32'd0, thresh}));
    return e;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result or a scheduled read.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_at_done", 64'(busy), 0);
          chk("pivot_i", 64'(pivot_i), 64'(e.pi));
          chk("pivot_j", 64'(pivot_j), 64'(e.pj));
          chk("M_ij", 64'(M_ij), 64'(e.mij));
          chk("M_abs", 64'(M_abs), 64'(e.mabs));
`ifdef PIVOT_THRESH_EN
          chk("converged", 64'(converged), 64'(e.conv));
`endif
          $display("scan: pivot (%0d,%0d) M_ij=0x%08h M_abs=0x%08h", pivot_i, pivot_j, M_ij, M_abs);
        end
      end
      if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
        rd_t r;
        r = rd_q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(r.v));
      end
    end
  end

  // All stimulus tasks enter and leave at a falling edge.
  task automatic write_elem(input int r, input int c, input logic [31:0] v, input bit dropped);
    rd_t q;
    wr_en = 1'b1; wr_row = 2'(r); wr_col = 2'(c); wr_data = v;
    rd_row = 2'(r); rd_col = 2'(c);
    q.cyc = cyc + 1; q.v = model[r][c];
    rd_q.push_back(q);
    if (!dropped) model[r][c] = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_elem(input int r, input int c);
    rd_t q;
    rd_row = 2'(r); rd_col = 2'(c);
    q.cyc = cyc + 1; q.v = model[r][c];
    rd_q.push_back(q);
    @(negedge clk);
    $display("read: (%0d,%0d) expect 0x%08h", r, c, q.v);
  endtask

  task automatic clear_mat();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        write_elem(r, c, 32'd0, 1'b0);
  endtask

  task automatic kick(input bit with_wr, input int r, input int c, input logic [31:0] v);
    start = 1'b1;
    exp_q.push_back(model_pivot(cyc + 1 + NP));
    if (with_wr) begin
      wr_en = 1'b1; wr_row = 2'(r); wr_col = 2'(c); wr_data = v;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    chk("busy_after_start", 64'(busy), 1);
`ifdef PIVOT_THRESH_EN
    chk("converged_cleared", 64'(converged), 0);
`endif
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: %0d results still pending after %0d cycles", exp_q.size(), k);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  logic [31:0] v;

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        model[r][c] = '0;
    repeat (2) @(negedge clk);
    chk("reset_rd_data", 64'(rd_data), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_pivot", {60'd0, pivot_i, pivot_j}, 0);
    chk("reset_M_ij", 64'(M_ij), 0);
    chk("reset_M_abs", 64'(M_abs), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity matrix.
    for (int d = 0; d < N; d++) write_elem(d, d, 32'd1, 1'b0);
    kick(1'b0, 0, 0, '0); wait_done();

    // Scan-order values 1,2,3,4,-5,2.
    write_elem(0, 1, 32'd1, 1'b0); write_elem(0, 2, 32'd2, 1'b0);
    write_elem(0, 3, 32'd3, 1'b0); write_elem(1, 2, 32'd4, 1'b0);
    write_elem(1, 3, -32'sd5, 1'b0); write_elem(2, 3, 32'd2, 1'b0);
    kick(1'b0, 0, 0, '0); wait_done();

    // Tie between 7 and -7, then the saturating most-negative value.
    clear_mat();
    write_elem(0, 2, 32'd7, 1'b0); write_elem(2, 3, -32'sd7, 1'b0);
    kick(1'b0, 0, 0, '0); wait_done();
    write_elem(0, 3, 32'h8000_0000, 1'b0);
    kick(1'b0, 0, 0, '0); wait_done();

    // Writes on the start cycle and during the scan are dropped.
    kick(1'b1, 3, 0, 32'd55);
    write_elem(0, 1, 32'd100, 1'b1);
    wait_done();
    read_elem(0, 1); read_elem(3, 0);

`ifdef PIVOT_THRESH_EN
    clear_mat();
    thresh = 32'd10;
    write_elem(0, 1, -32'sd9, 1'b0); write_elem(2, 3, 32'd4, 1'b0);
    kick(1'b0, 0, 0, '0); wait_done();
    write_elem(1, 2, 32'd10, 1'b0);
    kick(1'b0, 0, 0, '0); wait_done();
`endif

    // Randomised matrices with a bias towards small values (ties) and the extreme.
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          int sel;
          sel = int'($urandom_range(0, 9));
          if (sel < 4)      v = 32'($signed(int'($urandom_range(0, 6)) - 3));
          else if (sel == 9) v = 32'h8000_0000;
          else               v = $urandom;
          write_elem(r, c, v, 1'b0);
        end
      for (int k = 0; k < 3; k++)
        read_elem(int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)));
      thresh = $urandom_range(0, 8);
      kick(1'b0, 0, 0, '0); wait_done();
    end

    // Reset in the middle of a scan: everything clears, no result appears.
    write_elem(1, 3, 32'd77, 1'b0);
    kick(1'b0, 0, 0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy), 0);
    chk("midreset_done", 64'(done), 0);
    chk("midreset_pivot", {60'd0, pivot_i, pivot_j}, 0);
    chk("midreset_M_ij", 64'(M_ij), 0);
    chk("midreset_M_abs", 64'(M_abs), 0);
    chk("midreset_rd_data", 64'(rd_data), 0);
    exp_q.delete(); rd_q.delete();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        model[r][c] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    read_elem(1, 3); read_elem(2, 2);
    @(negedge clk);
    if (rd_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL read_pending: %0d reads never checked", rd_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
